// File: rtl/div_wb_ctrl.sv
// Divider issue/writeback controller: gates divider issue, stalls on hazards against the
// in-flight division, and merges its result into the shared register-file write port.
`ifndef DIV_PPL_STAGE
`define DIV_PPL_STAGE 4
`endif

module div_wb_ctrl #(
  parameter int unsigned DIV_LATENCY = `DIV_PPL_STAGE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_use_div,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_rd_we,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        div_finish,
  input  logic [4:0]  div_rd_addr,
  input  logic [31:0] div_rd_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] wb_rd_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        div_issue,
  output logic        stall,
  output logic        busy,
  output logic        err
);

  localparam int unsigned CNT_W = $clog2(DIV_LATENCY + 2);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

  state_t             r_state;
  logic [4:0]         r_pend_rd;
  logic [31:0]        r_hold_data;
  logic [CNT_W-1:0]   r_lat_cnt;
  logic               r_err;

  logic w_idle, w_busy_st, w_hold_st;
  logic w_hazard, w_fin_busy, w_direct, w_to_hold, w_drain, w_timeout, w_err_ev;

  always_comb begin
    w_idle     = (r_state == S_IDLE);
    w_busy_st  = (r_state == S_BUSY);
    w_hold_st  = (r_state == S_HOLD);
    w_hazard   = !w_idle && (r_pend_rd != 5'd0) &&
                 ((id_rs1_used && (id_rs1_addr == r_pend_rd)) ||
                  (id_rs2_used && (id_rs2_addr == r_pend_rd)) ||
                  (id_rd_we    && (id_rd_addr  == r_pend_rd)));
    w_fin_busy = w_busy_st && div_finish;
    w_direct   = w_fin_busy && (!wb_we || (div_rd_addr == 5'd0));
    w_to_hold  = w_fin_busy && wb_we && (div_rd_addr != 5'd0);
    w_drain    = w_hold_st && !wb_we;
    w_timeout  = w_busy_st && !div_finish && (r_lat_cnt == CNT_W'(DIV_LATENCY + 1));
    // Stray finish, wrong destination, or a division that never came back
    w_err_ev   = (div_finish && !w_busy_st) ||
                 (w_fin_busy && (div_rd_addr != r_pend_rd)) ||
                 w_timeout;
  end

  always_comb begin
    div_issue = id_use_div && w_idle && !rst;
    stall     = w_hazard || (id_use_div && !w_idle) || w_hold_st;
    busy      = !w_idle;
    err       = r_err;
  end

  // Write-port mux: main pipeline first, then direct finish, then hold drain
  always_comb begin
    rf_we    = wb_we && (wb_rd_addr != 5'd0);
    rf_waddr = wb_rd_addr;
    rf_wdata = wb_rd_data;
    if (!wb_we) begin
      if (w_direct && (div_rd_addr != 5'd0)) begin
        rf_we    = 1'b1;
        rf_waddr = div_rd_addr;
        rf_wdata = div_rd_data;
      end else if (w_drain) begin
        rf_we    = 1'b1;
        rf_waddr = r_pend_rd;
        rf_wdata = r_hold_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pend_rd   <= 5'd0;
      r_hold_data <= 32'd0;
      r_lat_cnt   <= CNT_W'(0);
      r_err       <= 1'b0;
    end else begin
      r_err <= w_err_ev;
      case (r_state)
        S_IDLE: begin
          if (id_use_div) begin
            r_state   <= S_BUSY;
            r_pend_rd <= id_rd_addr;
            r_lat_cnt <= CNT_W'(1);
          end
        end
        S_BUSY: begin
          if (div_finish) begin
            r_lat_cnt <= CNT_W'(0);
            if (w_to_hold) begin
              // Buffer under the address the divider reported so the drain honours it
              r_hold_data <= div_rd_data;
              r_pend_rd   <= div_rd_addr;
              r_state     <= S_HOLD;
            end else begin
              r_pend_rd <= 5'd0;
              r_state   <= S_IDLE;
            end
          end else if (w_timeout) begin
            r_lat_cnt <= CNT_W'(0);
            r_pend_rd <= 5'd0;
            r_state   <= S_IDLE;
          end else begin
            r_lat_cnt <= r_lat_cnt + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (!wb_we) begin
            r_pend_rd <= 5'd0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_wb_ctrl.sv
// Self-checking bench for div_wb_ctrl: directed scenarios plus randomized issue/finish/collision runs.
module tb_div_wb_ctrl;

  localparam int L = 4;

  logic        clk;
  logic        rst;
  logic        id_use_div, id_rd_we, id_rs1_used, id_rs2_used;
  logic [4:0]  id_rd_addr, id_rs1_addr, id_rs2_addr;
  logic        div_finish;
  logic [4:0]  div_rd_addr;
  logic [31:0] div_rd_data;
  logic        wb_we;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic        rf_we, div_issue, stall, busy, err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_tests;
  int n_fail;

  div_wb_ctrl #(.DIV_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .id_use_div(id_use_div), .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .div_finish(div_finish), .div_rd_addr(div_rd_addr), .div_rd_data(div_rd_data),
    .wb_we(wb_we), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .div_issue(div_issue), .stall(stall), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_in();
    id_use_div = 0; id_rd_we = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd_addr = 0; id_rs1_addr = 0; id_rs2_addr = 0;
    div_finish = 0; div_rd_addr = 0; div_rd_data = 0;
    wb_we = 0; wb_rd_addr = 0; wb_rd_data = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    clear_in();
    id_use_div = 1; id_rd_addr = rd; id_rd_we = 1;
    @(negedge clk);
    n_tests++;
    if (div_issue !== 1'b1) begin n_fail++; $display("FAIL issue_%0d: div_issue=%b expected 1", rd, div_issue); end
    next();
    clear_in();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    d = $urandom;
    clear_in();
    id_use_div = 1; wb_we = 1; wb_rd_addr = 5'd7; wb_rd_data = d;
    @(negedge clk);
    n_tests++;
    if (stall !== 0 || div_issue !== 0 || busy !== 0 || err !== 0) begin
      n_fail++; $display("FAIL reset_ctrl: stall=%b issue=%b busy=%b err=%b expected 0000", stall, div_issue, busy, err);
    end
    n_tests++;
    if (rf_we !== 1 || rf_waddr !== 5'd7 || rf_wdata !== d) begin
      n_fail++; $display("FAIL reset_port: we=%b addr=%0d data=%h expected 1 7 %h", rf_we, rf_waddr, rf_wdata, d);
    end
    clear_in();
    rst = 0;
    next();
  endtask

  task automatic test_direct();
    issue(5'd5);
    for (int c = 1; c <= L + 1; c++) begin
      clear_in();
      if (c == L) begin div_finish = 1; div_rd_addr = 5'd5; div_rd_data = 32'h7; end
      @(negedge clk);
      n_tests++;
      if (busy !== (c <= L)) begin n_fail++; $display("FAIL direct_busy_T%0d: busy=%b expected %b", c, busy, c <= L); end
      n_tests++;
      if (rf_we !== (c == L)) begin n_fail++; $display("FAIL direct_we_T%0d: rf_we=%b expected %b", c, rf_we, c == L); end
      if (c == L) begin
        n_tests++;
        if (rf_waddr !== 5'd5 || rf_wdata !== 32'h7) begin
          n_fail++; $display("FAIL direct_port: addr=%0d data=%h expected 5 7", rf_waddr, rf_wdata);
        end
      end
      next();
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    d = $urandom;
    issue(5'd5);
    for (int c = 1; c <= L + 2; c++) begin
      clear_in();
      if (c == L) begin
        div_finish = 1; div_rd_addr = 5'd5; div_rd_data = d;
        wb_we = 1; wb_rd_addr = 5'd3; wb_rd_data = 32'hAAAA_0000;
      end
      @(negedge clk);
      if (c == L) begin
        n_tests++;
        if (rf_we !== 1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hAAAA_0000) begin
          n_fail++; $display("FAIL coll_wb: we=%b addr=%0d data=%h expected 1 3 aaaa0000", rf_we, rf_waddr, rf_wdata);
        end
      end else if (c == L + 1) begin
        n_tests++;
        if (rf_we !== 1 || rf_waddr !== 5'd5 || rf_wdata !== d) begin
          n_fail++; $display("FAIL coll_drain: we=%b addr=%0d data=%h expected 1 5 %h", rf_we, rf_waddr, rf_wdata, d);
        end
        n_tests++;
        if (stall !== 1 || busy !== 1) begin n_fail++; $display("FAIL coll_hold: stall=%b busy=%b expected 1 1", stall, busy); end
      end else if (c == L + 2) begin
        n_tests++;
        if (busy !== 0 || stall !== 0 || rf_we !== 0 || err !== 0) begin
          n_fail++; $display("FAIL coll_after: busy=%b stall=%b we=%b err=%b expected 0000", busy, stall, rf_we, err);
        end
      end
      next();
    end
  endtask

  task automatic test_hazard();
    issue(5'd5);
    for (int c = 1; c <= L + 1; c++) begin
      clear_in();
      case (c % 3)
        0:       begin id_rd_we = 1; id_rd_addr = 5'd5; end
        1:       begin id_rs2_used = 1; id_rs2_addr = 5'd5; end
        default: begin id_rs1_used = 1; id_rs1_addr = 5'd5; end
      endcase
      if (c == L + 1) begin id_rd_we = 0; id_rs1_used = 0; id_rs2_used = 1; id_rs2_addr = 5'd5; end
      if (c == L) begin div_finish = 1; div_rd_addr = 5'd5; div_rd_data = $urandom; end
      @(negedge clk);
      n_tests++;
      if (stall !== (c <= L)) begin n_fail++; $display("FAIL hazard_T%0d: stall=%b expected %b", c, stall, c <= L); end
      next();
    end
    // Division targeting x0 must not stall an x0 reader
    issue(5'd0);
    for (int c = 1; c <= L + 1; c++) begin
      clear_in();
      id_rs1_used = 1; id_rs1_addr = 5'd0;
      if (c == L) begin div_finish = 1; div_rd_addr = 5'd0; div_rd_data = $urandom; end
      @(negedge clk);
      n_tests++;
      if (stall !== 0 || rf_we !== 0) begin n_fail++; $display("FAIL hazard_x0_T%0d: stall=%b we=%b expected 0 0", c, stall, rf_we); end
      next();
    end
  endtask

  task automatic test_back_to_back();
    issue(5'd9);
    for (int c = 1; c <= L + 1; c++) begin
      clear_in();
      if (c == L) begin
        div_finish = 1; div_rd_addr = 5'd9; div_rd_data = $urandom;
        id_use_div = 1; id_rd_addr = 5'd10; id_rd_we = 1;
      end
      if (c == L + 1) begin id_use_div = 1; id_rd_addr = 5'd10; id_rd_we = 1; end
      @(negedge clk);
      if (c == L) begin
        n_tests++;
        if (div_issue !== 0 || stall !== 1 || rf_we !== 1) begin
          n_fail++; $display("FAIL b2b_finish: issue=%b stall=%b we=%b expected 0 1 1", div_issue, stall, rf_we);
        end
      end else if (c == L + 1) begin
        n_tests++;
        if (div_issue !== 1 || stall !== 0 || busy !== 0) begin
          n_fail++; $display("FAIL b2b_next: issue=%b stall=%b busy=%b expected 1 0 0", div_issue, stall, busy);
        end
      end
      next();
    end
    for (int c = 1; c <= L + 1; c++) begin
      clear_in();
      if (c == L) begin div_finish = 1; div_rd_addr = 5'd10; div_rd_data = $urandom; end
      @(negedge clk);
      n_tests++;
      if (busy !== (c <= L)) begin n_fail++; $display("FAIL b2b_second_T%0d: busy=%b expected %b", c, busy, c <= L); end
      next();
    end
  endtask

  task automatic test_timeout();
    issue(5'd5);
    for (int c = 1; c <= L + 3; c++) begin
      clear_in();
      id_rs1_used = 1; id_rs1_addr = 5'd5;
      @(negedge clk);
      n_tests++;
      if (busy !== (c <= L + 1) || stall !== (c <= L + 1)) begin
        n_fail++; $display("FAIL timeout_busy_T%0d: busy=%b stall=%b expected %b", c, busy, stall, c <= L + 1);
      end
      n_tests++;
      if (err !== (c == L + 2)) begin n_fail++; $display("FAIL timeout_err_T%0d: err=%b expected %b", c, err, c == L + 2); end
      next();
    end
  endtask

  task automatic test_async_reset();
    issue(5'd5);
    next();
    id_rs2_used = 1; id_rs2_addr = 5'd5; id_use_div = 1;
    #1;
    n_tests++;
    if (stall !== 1 || busy !== 1) begin n_fail++; $display("FAIL areset_pre: stall=%b busy=%b expected 1 1", stall, busy); end
    #1 rst = 1;
    #1;
    n_tests++;
    if (stall !== 0 || busy !== 0 || err !== 0 || div_issue !== 0) begin
      n_fail++; $display("FAIL areset_now: stall=%b busy=%b err=%b issue=%b expected 0000", stall, busy, err, div_issue);
    end
    @(negedge clk);
    clear_in();
    rst = 0;
    next();
    div_finish = 1; div_rd_addr = 5'd5; div_rd_data = $urandom;
    @(negedge clk);
    n_tests++;
    if (rf_we !== 0) begin n_fail++; $display("FAIL areset_stray_we: rf_we=%b expected 0", rf_we); end
    next();
    clear_in();
    @(negedge clk);
    n_tests++;
    if (err !== 1) begin n_fail++; $display("FAIL areset_stray_err: err=%b expected 1", err); end
    next();
    @(negedge clk);
    n_tests++;
    if (err !== 0) begin n_fail++; $display("FAIL areset_err_clear: err=%b expected 0", err); end
    next();
  endtask

  // Model: write lands at L unless WB owns the port, else on the first free WB cycle
  task automatic test_random();
    logic [4:0]  rd, faddr;
    logic [31:0] d;
    bit          coll, mism;
    int          k, wc;
    bit          e_busy, e_stall, e_err, e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    for (int it = 0; it < 25; it++) begin
      rd    = 5'($urandom_range(1, 31));
      d     = $urandom;
      coll  = ($urandom_range(0, 1) == 1);
      mism  = ($urandom_range(0, 3) == 0);
      k     = coll ? int'($urandom_range(0, 2)) : 0;
      faddr = rd;
      if (mism) faddr = (rd == 5'd31) ? 5'd1 : rd + 5'd1;
      wc    = coll ? L + 1 + k : L;
      for (int c = 0; c <= wc + 1; c++) begin
        clear_in();
        if (c == 0) begin id_use_div = 1; id_rd_addr = rd; id_rd_we = 1; end
        if (c == L) begin div_finish = 1; div_rd_addr = faddr; div_rd_data = d; end
        if (coll && c >= L && c <= L + k) begin
          wb_we = 1; wb_rd_addr = 5'($urandom_range(1, 31)); wb_rd_data = $urandom;
        end
        e_busy  = (c >= 1) && (c <= wc);
        e_stall = coll && (c > L) && (c <= wc);
        e_err   = mism && (c == L + 1);
        e_we    = wb_we || (c == wc);
        e_addr  = wb_we ? wb_rd_addr : faddr;
        e_data  = wb_we ? wb_rd_data : d;
        @(negedge clk);
        n_tests++;
        if (busy !== e_busy || stall !== e_stall || err !== e_err || div_issue !== (c == 0)) begin
          n_fail++;
          $display("FAIL rand%0d_ctrl_c%0d: busy=%b stall=%b err=%b issue=%b expected %b %b %b %b",
                   it, c, busy, stall, err, div_issue, e_busy, e_stall, e_err, c == 0);
        end
        n_tests++;
        if (rf_we !== e_we || (e_we && (rf_waddr !== e_addr || rf_wdata !== e_data))) begin
          n_fail++;
          $display("FAIL rand%0d_port_c%0d: we=%b addr=%0d data=%h expected %b %0d %h",
                   it, c, rf_we, rf_waddr, rf_wdata, e_we, e_addr, e_data);
        end
        next();
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1;
    clear_in();
    #2;
    test_reset();
    test_direct();
    test_collision();
    test_hazard();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
